// File: rtl/count_fifo_reader_pkg.sv
// Shared constants and types for the count FIFO reader and the SPI register map.
//   COUNT_W            width of one count word from the pre-buffer stage
//   BYTES_PER_WORD     bytes served to the SPI slave per count word
//   FIFO_DEPTH_DEFAULT default FIFO depth in words
//   reader_state_e     byte-serialiser FSM encoding
package count_fifo_reader_pkg;

  localparam int COUNT_W            = 24;
  localparam int BYTES_PER_WORD     = COUNT_W / 8;
  localparam int FIFO_DEPTH_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } reader_state_e;

endpackage

// File: rtl/count_fifo_reader_sync_fifo_mem.sv
// sync_fifo_mem: single-clock word FIFO with level counter and drop detect.
// Ports:
//   clk_12mhz, n_reset  clock, async active-low reset
//   wr_en, wr_data      write strobe and word
//   pop                 remove head word (ignored when empty)
//   rd_data             current head word (combinational read of storage)
//   level               words stored, 0..DEPTH
//   full, empty         decodes of level
//   drop                write presented while full with no pop in the same cycle
module sync_fifo_mem #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_12mhz,
  input  logic              n_reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              pop_ok;
  logic              wr_accept;

  assign full  = (level_q == (ADDR_W+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a write against a full FIFO
  // is still accepted when the head is leaving.
  assign pop_ok    = pop & ~empty;
  assign wr_accept = wr_en & (~full | pop_ok);
  assign drop      = wr_en & full & ~pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_accept, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_12mhz or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_12mhz) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/count_fifo_reader.sv
// count_fifo_reader: buffers count words and serves them to the SPI slave
// as bytes, MSB first.
// Ports:
//   clk_12mhz, n_reset  clock, async active-low reset
//   wr_data, wr_en      count word and write strobe from the pre-buffer stage
//   byte_rd             SPI slave consumed the current byte
//   byte_out, byte_valid, byte_idx   current byte of the staged word
//   fifo_level, fifo_full, fifo_empty  FIFO status (staged word excluded)
//   overflow, clr_overflow            sticky drop flag and its clear
//
// state | meaning
// IDLE  | nothing staged; pop the FIFO head as soon as one exists
// SERVE | staged word being read out byte by byte, byte_valid=1
module count_fifo_reader
  import count_fifo_reader_pkg::*;
#(
  parameter int DATA_W = COUNT_W,
  parameter int DEPTH  = FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W = 4
) (
  input  logic              clk_12mhz,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              byte_rd,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  output logic [1:0]        byte_idx,
  output logic [ADDR_W:0]   fifo_level,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam logic [1:0] LAST_IDX = 2'(DATA_W/8 - 1);

  reader_state_e     state_q, state_d;
  logic [DATA_W-1:0] staged_q, staged_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;

  logic              pop;
  logic [DATA_W-1:0] head;
  logic              drop;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_12mhz (clk_12mhz),
    .n_reset   (n_reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .pop       (pop),
    .rd_data   (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (drop)
  );

  function automatic logic [7:0] pick_byte(logic [DATA_W-1:0] word, logic [1:0] idx);
    return word[DATA_W-1-8*int'(idx) -: 8];
  endfunction

  always_comb begin
    state_d    = state_q;
    staged_d   = staged_q;
    idx_d      = idx_q;
    byte_out_d = byte_out_q;
    valid_d    = valid_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          staged_d   = head;
          idx_d      = '0;
          byte_out_d = pick_byte(head, 2'd0);
          valid_d    = 1'b1;
          state_d    = SERVE;
        end
      end
      SERVE: begin
        if (byte_rd) begin
          if (idx_q != LAST_IDX) begin
            idx_d      = idx_q + 1'b1;
            byte_out_d = pick_byte(staged_q, idx_q + 1'b1);
          end else if (!fifo_empty) begin
            // Reload on the last byte so the next word follows with no gap.
            pop        = 1'b1;
            staged_d   = head;
            idx_d      = '0;
            byte_out_d = pick_byte(head, 2'd0);
          end else begin
            idx_d      = '0;
            byte_out_d = 8'h00;
            valid_d    = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A drop in the same cycle as a clear must leave the flag set.
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk_12mhz or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      staged_q   <= '0;
      idx_q      <= '0;
      byte_out_q <= 8'h00;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      staged_q   <= staged_d;
      idx_q      <= idx_d;
      byte_out_q <= byte_out_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = valid_q;
  assign byte_idx   = idx_q;
  assign overflow   = overflow_q;

endmodule
